// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   Carry-pipelined add/subtract unit with a valid/ready stream handshake.
//   The operands are split into STAGES segments of WIDTH/STAGES bits. Segment i
//   is summed in stage i using the carry registered by stage i-1. Operand bits
//   not yet summed and result bits already finished travel along with the beat.
//   Flags (carry/borrow, signed overflow, zero) are formed at the final stage.
//
//   Parameters
//     WIDTH   operand/result width (must be a multiple of STAGES)
//     STAGES  pipeline depth = number of carry segments (>= 1)
//
//   Ports
//     clk, rst              clock; synchronous active-high reset
//     in_valid/in_ready     operand beat handshake
//     in_a, in_b            operands
//     in_op                 1 = A + B + cbin, 0 = A - B - cbin
//     in_cbin               carry-in (add) / borrow-in (sub)
//     out_valid/out_ready   result beat handshake
//     out_result            result
//     out_cout              add: carry-out; sub: borrow-out
//     out_ovf               signed two's-complement overflow
//     out_zero              out_result == 0
//
//   Optional build macro
//     ADDSUB_SATURATE_EN    clamp the result to the signed extreme on overflow
// -----------------------------------------------------------------------------
module pipelined_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   input  logic             in_cbin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

`ifdef ADDSUB_SATURATE_EN
   // Clamp toward the signed extreme on the side the overflow happened.
   // When both addends share a sign and overflow occurs, that sign tells
   // the direction: positive operands overflow upward, negative downward.
   function automatic logic signed [WIDTH-1:0] saturate(
      input logic signed [WIDTH-1:0] raw,
      input logic                    ovf,
      input logic                    a_neg
   );
      if (!ovf)
         return raw;
      else if (a_neg)
         return {1'b1, {(WIDTH-1){1'b0}}};
      else
         return {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   logic advance;

   // Pipeline registers, one entry per stage.
   logic [WIDTH-1:0] a_p   [STAGES];
   logic [WIDTH-1:0] bx_p  [STAGES];   // B (add) or ~B (sub)
   logic [WIDTH-1:0] res_p [STAGES];   // finished low segments
   logic             cy_p  [STAGES];   // carry out of the segment just summed
   logic             op_p  [STAGES];
   logic             vld_p [STAGES];

   // Values presented to each stage register.
   logic [WIDTH-1:0] a_s   [STAGES];
   logic [WIDTH-1:0] bx_s  [STAGES];
   logic [WIDTH-1:0] res_s [STAGES];
   logic             cy_s  [STAGES];
   logic             op_s  [STAGES];
   logic             vld_s [STAGES];
   logic [SEG:0]     sum_s [STAGES];

   logic [WIDTH-1:0] raw_fin;
   logic [WIDTH-1:0] res_fin;
   logic             ovf_fin;
   logic             cout_fin;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   always_comb begin
      // Subtraction is A + ~B + !cbin, so borrow-in is folded into the carry-in.
      a_s[0]   = in_a;
      bx_s[0]  = in_op ? in_b : ~in_b;
      res_s[0] = '0;
      cy_s[0]  = in_op ? in_cbin : ~in_cbin;
      op_s[0]  = in_op;
      vld_s[0] = in_valid;
      for (int i = 1; i < STAGES; i++) begin
         a_s[i]   = a_p[i-1];
         bx_s[i]  = bx_p[i-1];
         res_s[i] = res_p[i-1];
         cy_s[i]  = cy_p[i-1];
         op_s[i]  = op_p[i-1];
         vld_s[i] = vld_p[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
         sum_s[i] = {1'b0, a_s[i][i*SEG +: SEG]} + {1'b0, bx_s[i][i*SEG +: SEG]}
                  + {{SEG{1'b0}}, cy_s[i]};
         res_s[i][i*SEG +: SEG] = sum_s[i][SEG-1:0];
      end
   end

   // ---- stage registers: control ----
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
      end else if (advance) begin
         for (int i = 0; i < STAGES; i++) vld_p[i] <= vld_s[i];
      end
   end

   // ---- stage registers: data ----
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int i = 0; i < STAGES; i++) begin
            a_p[i]   <= a_s[i];
            bx_p[i]  <= bx_s[i];
            res_p[i] <= res_s[i];
            cy_p[i]  <= sum_s[i][SEG];
            op_p[i]  <= op_s[i];
         end
      end
   end

   // ---- final stage: flags and output ----
   assign raw_fin  = res_p[LAST];
   assign ovf_fin  = (a_p[LAST][WIDTH-1] == bx_p[LAST][WIDTH-1])
                  && (raw_fin[WIDTH-1] != a_p[LAST][WIDTH-1]);
   // The adder produces carry; for subtraction a missing carry means borrow.
   assign cout_fin = op_p[LAST] ? cy_p[LAST] : ~cy_p[LAST];

`ifdef ADDSUB_SATURATE_EN
   assign res_fin = saturate(raw_fin, ovf_fin, a_p[LAST][WIDTH-1]);
`else
   assign res_fin = raw_fin;
`endif

   // Data registers are not reset, so outputs are gated by the valid bit.
   assign out_valid  = vld_p[LAST];
   assign out_result = out_valid ? res_fin : '0;
   assign out_cout   = out_valid && cout_fin;
   assign out_ovf    = out_valid && ovf_fin;
   assign out_zero   = out_valid && (res_fin == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // WIDTH=16, STAGES=4 instance
   logic        in_valid, in_ready, in_op, in_cbin;
   logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
   logic [15:0] in_a, in_b, out_result;

   // WIDTH=8, STAGES=1 instance
   logic        s_in_valid, s_in_ready, s_in_op, s_in_cbin;
   logic        s_out_valid, s_out_ready, s_out_cout, s_out_ovf, s_out_zero;
   logic [7:0]  s_in_a, s_in_b, s_out_result;

   int total = 0;
   int bad   = 0;

`ifdef ADDSUB_SATURATE_EN
   localparam logic [15:0] EXP_POS_OVF   = 16'h7FFF;
   localparam logic [15:0] EXP_NEG_OVF   = 16'h8000;
   localparam logic [7:0]  S_EXP_POS_OVF = 8'h7F;
   localparam logic [7:0]  S_EXP_NEG_OVF = 8'h80;
`else
   localparam logic [15:0] EXP_POS_OVF   = 16'h8000;
   localparam logic [15:0] EXP_NEG_OVF   = 16'h7FFF;
   localparam logic [7:0]  S_EXP_POS_OVF = 8'h80;
   localparam logic [7:0]  S_EXP_NEG_OVF = 8'h7F;
`endif

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cbin(in_cbin),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_cout(out_cout),
      .out_ovf(out_ovf), .out_zero(out_zero)
   );

   pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_s (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_cbin(s_in_cbin),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_result(s_out_result), .out_cout(s_out_cout),
      .out_ovf(s_out_ovf), .out_zero(s_out_zero)
   );

   // Drives one beat into an empty pipe (called just after a rising edge),
   // waits for its result and returns it together with the observed latency
   // in edges after the accepting edge. The result is consumed before return.
   task automatic beat(input bit sm, input logic [15:0] a, input logic [15:0] b,
                       input logic op, input logic cb,
                       output logic [15:0] r, output logic c, output logic v,
                       output logic z, output int lat);
      if (sm) begin
         s_in_a = a[7:0]; s_in_b = b[7:0]; s_in_op = op; s_in_cbin = cb; s_in_valid = 1'b1;
      end else begin
         in_a = a; in_b = b; in_op = op; in_cbin = cb; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; s_in_valid = 1'b0;
      lat = 0;
      while (!(sm ? s_out_valid : out_valid) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (sm) begin
         r = {8'h00, s_out_result}; c = s_out_cout; v = s_out_ovf; z = s_out_zero;
      end else begin
         r = out_result; c = out_cout; v = out_ovf; z = out_zero;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_cbin = 1'b0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_op = 1'b0; s_in_cbin = 1'b0;
      s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (out_result !== 16'h0000) begin bad++; $display("FAIL rst_out_result got=%h want=0000", out_result); end
      total++; if ({out_cout, out_ovf, out_zero} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {out_cout, out_ovf, out_zero}); end
      total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst_s_out_valid got=%b want=0", s_out_valid); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
      total++; if (s_in_ready !== 1'b1) begin bad++; $display("FAIL rst_s_in_ready got=%b want=1", s_in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_sub_basic();
      logic [15:0] r; logic c, v, z; int lat;
      beat(1'b0, 16'h1234, 16'h0234, 1'b0, 1'b0, r, c, v, z, lat);
      total++; if (r !== 16'h1000) begin bad++; $display("FAIL sub_res got=%h want=1000", r); end
      total++; if ({c, v, z} !== 3'b000) begin bad++; $display("FAIL sub_flags got=%b want=000", {c, v, z}); end
      total++; if (lat !== 3) begin bad++; $display("FAIL sub_latency got=%0d want=3", lat); end
   endtask

   task automatic test_boundaries();
      logic [15:0] r; logic c, v, z; int lat;
      beat(1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, r, c, v, z, lat);
      total++; if (r !== 16'hFFFF) begin bad++; $display("FAIL wrap_sub_res got=%h want=ffff", r); end
      total++; if ({c, v, z} !== 3'b100) begin bad++; $display("FAIL wrap_sub_flags got=%b want=100", {c, v, z}); end
      beat(1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, r, c, v, z, lat);
      total++; if (r !== 16'h0000) begin bad++; $display("FAIL wrap_add_res got=%h want=0000", r); end
      total++; if ({c, v, z} !== 3'b101) begin bad++; $display("FAIL wrap_add_flags got=%b want=101", {c, v, z}); end
      beat(1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b1, r, c, v, z, lat);
      total++; if (r !== 16'h0100) begin bad++; $display("FAIL cbin_add_res got=%h want=0100", r); end
      total++; if ({c, v, z} !== 3'b000) begin bad++; $display("FAIL cbin_add_flags got=%b want=000", {c, v, z}); end
      beat(1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, r, c, v, z, lat);
      total++; if (r !== 16'h00FF) begin bad++; $display("FAIL bin_sub_res got=%h want=00ff", r); end
   endtask

   task automatic test_overflow();
      logic [15:0] r; logic c, v, z; int lat;
      beat(1'b0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, r, c, v, z, lat);
      total++; if (r !== EXP_POS_OVF) begin bad++; $display("FAIL pos_ovf_res got=%h want=%h", r, EXP_POS_OVF); end
      total++; if ({c, v} !== 2'b01) begin bad++; $display("FAIL pos_ovf_flags got=%b want=01", {c, v}); end
      beat(1'b0, 16'h8000, 16'h0001, 1'b0, 1'b0, r, c, v, z, lat);
      total++; if (r !== EXP_NEG_OVF) begin bad++; $display("FAIL neg_ovf_res got=%h want=%h", r, EXP_NEG_OVF); end
      total++; if ({c, v} !== 2'b01) begin bad++; $display("FAIL neg_ovf_flags got=%b want=01", {c, v}); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [8] = '{16'h0001, 16'h1111, 16'h5000, 16'h0FFF, 16'h1000, 16'hABCD, 16'h0100, 16'h4000};
      logic [15:0] vb [8] = '{16'h0002, 16'h2222, 16'h1000, 16'h0001, 16'h0001, 16'h1111, 16'h0200, 16'h0004};
      logic        vo [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] vr [8] = '{16'h0003, 16'h3333, 16'h4000, 16'h1000, 16'h0FFF, 16'hBCDE, 16'hFF00, 16'h4004};
      int sent = 0, recv = 0, cyc = 0, extra = 0;
      logic acc;
      logic [15:0] held = '0;
      while (recv < 8 && cyc < 60) begin
         in_valid  = (sent < 8);
         in_a      = va[(sent < 8) ? sent : 0];
         in_b      = vb[(sent < 8) ? sent : 0];
         in_op     = vo[(sent < 8) ? sent : 0];
         in_cbin   = 1'b0;
         out_ready = !(cyc >= 5 && cyc <= 7);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (!out_ready && out_valid) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
            if (cyc > 5) begin
               total++; if (out_result !== held) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, out_result, held); end
            end
            held = out_result;
         end
         if (out_valid && out_ready) begin
            total++; if (out_result !== vr[recv]) begin bad++; $display("FAIL b2b_res idx=%0d got=%h want=%h", recv, out_result, vr[recv]); end
            recv++;
         end
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++; if (recv !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", recv); end
      repeat (6) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL b2b_dup got=%0d want=0", extra); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_inflight();
      int seen = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = 16'h0010 + 16'(i); in_b = 16'h0001; in_op = 1'b1; in_cbin = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
      total++; if (out_result !== 16'h0000) begin bad++; $display("FAIL flush_out_result got=%h want=0000", out_result); end
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL flush_ghosts got=%0d want=0", seen); end
   endtask

   task automatic test_small();
      logic [15:0] r; logic c, v, z; int lat;
      beat(1'b1, 16'h0034, 16'h0004, 1'b0, 1'b0, r, c, v, z, lat);
      total++; if (r[7:0] !== 8'h30) begin bad++; $display("FAIL s_sub_res got=%h want=30", r[7:0]); end
      total++; if (lat !== 0) begin bad++; $display("FAIL s_latency got=%0d want=0", lat); end
      beat(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, r, c, v, z, lat);
      total++; if ({r[7:0], c} !== {8'hFF, 1'b1}) begin bad++; $display("FAIL s_wrap_sub got=%h/%b want=ff/1", r[7:0], c); end
      beat(1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b0, r, c, v, z, lat);
      total++; if ({r[7:0], c, z} !== {8'h00, 2'b11}) begin bad++; $display("FAIL s_wrap_add got=%h/%b%b want=00/11", r[7:0], c, z); end
      beat(1'b1, 16'h000F, 16'h0000, 1'b1, 1'b1, r, c, v, z, lat);
      total++; if (r[7:0] !== 8'h10) begin bad++; $display("FAIL s_cbin got=%h want=10", r[7:0]); end
      beat(1'b1, 16'h007F, 16'h0001, 1'b1, 1'b0, r, c, v, z, lat);
      total++; if ({r[7:0], v} !== {S_EXP_POS_OVF, 1'b1}) begin bad++; $display("FAIL s_pos_ovf got=%h/%b want=%h/1", r[7:0], v, S_EXP_POS_OVF); end
      beat(1'b1, 16'h0080, 16'h0001, 1'b0, 1'b0, r, c, v, z, lat);
      total++; if ({r[7:0], v} !== {S_EXP_NEG_OVF, 1'b1}) begin bad++; $display("FAIL s_neg_ovf got=%h/%b want=%h/1", r[7:0], v, S_EXP_NEG_OVF); end
   endtask

   initial begin
      test_reset();
      test_sub_basic();
      test_boundaries();
      test_overflow();
      test_back_to_back();
      test_reset_inflight();
      test_small();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
